// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit with architectural HI/LO registers.
// One product/quotient bit is resolved per clock; signs are handled on magnitudes and fixed up afterwards.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int W  = WIDTH;
  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FIXUP = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]     state_reg;
  logic [CW-1:0]  cnt_reg;
  logic           div_reg;
  logic           sgn_a_reg;
  logic           neg_reg;
  logic           dbz_reg;
  logic [W-1:0]   a_raw_reg;
  logic [W:0]     mag_a_reg;
  logic [W:0]     mag_b_reg;
  logic [2*W-1:0] acc_reg;

  logic [W:0]     a_ext, b_ext, mag_a, mag_b;
  logic [W:0]     mul_sum;
  logic [W:0]     div_shift;
  logic           div_ge;
  logic [W-1:0]   div_rem;
  logic [2*W-1:0] step_acc;
  logic [2*W-1:0] fix_acc;
  logic [W-1:0]   quo, rem;

  assign busy = (state_reg != S_IDLE);

  // Signed operands are widened one bit so |most-negative| is representable.
  always_comb begin
    a_ext = {op[0] & a[W-1], a};
    b_ext = {op[0] & b[W-1], b};
    mag_a = a_ext[W] ? -a_ext : a_ext;
    mag_b = b_ext[W] ? -b_ext : b_ext;
  end

  // Multiply: acc = {partial product, remaining multiplier bits}.
  // Divide:   acc = {partial remainder, remaining dividend bits / quotient bits}.
  always_comb begin
    mul_sum   = {1'b0, acc_reg[2*W-1:W]} + (acc_reg[0] ? mag_a_reg : '0);
    div_shift = acc_reg[2*W-1:W-1];
    div_ge    = (div_shift >= mag_b_reg);
    div_rem   = div_ge ? (div_shift[W-1:0] - mag_b_reg[W-1:0]) : div_shift[W-1:0];
    if (div_reg)
      step_acc = {div_rem, acc_reg[W-2:0], div_ge};
    else
      step_acc = {mul_sum, acc_reg[W-1:1]};
  end

  always_comb begin
    quo = acc_reg[W-1:0];
    rem = acc_reg[2*W-1:W];
    if (!div_reg)
      fix_acc = neg_reg ? -acc_reg : acc_reg;
    else if (mag_b_reg == '0)
      fix_acc = {a_raw_reg, {W{1'b1}}};
    else
      fix_acc = {(sgn_a_reg ? -rem : rem), (neg_reg ? -quo : quo)};
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg   <= S_IDLE;
      cnt_reg     <= '0;
      div_reg     <= 1'b0;
      sgn_a_reg   <= 1'b0;
      neg_reg     <= 1'b0;
      dbz_reg     <= 1'b0;
      a_raw_reg   <= '0;
      mag_a_reg   <= '0;
      mag_b_reg   <= '0;
      acc_reg     <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          // Direct writes are blocked in the cycle the result is presented.
          if (hi_we && !done) hi <= wdata;
          if (lo_we && !done) lo <= wdata;
          if (start) begin
            state_reg <= S_RUN;
            cnt_reg   <= '0;
            div_reg   <= op[1];
            sgn_a_reg <= a_ext[W];
            neg_reg   <= a_ext[W] ^ b_ext[W];
            dbz_reg   <= 1'b0;
            a_raw_reg <= a;
            mag_a_reg <= mag_a;
            mag_b_reg <= mag_b;
            acc_reg   <= op[1] ? {{W{1'b0}}, mag_a[W-1:0]} : {{W{1'b0}}, mag_b[W-1:0]};
          end
        end
        S_RUN: begin
          if (cancel) begin
            state_reg <= S_IDLE;
          end else begin
            acc_reg <= step_acc;
            cnt_reg <= cnt_reg + 1'b1;
            if (cnt_reg == CW'(WIDTH - 1)) state_reg <= S_FIXUP;
          end
        end
        S_FIXUP: begin
          if (cancel) begin
            state_reg <= S_IDLE;
          end else begin
            acc_reg   <= fix_acc;
            dbz_reg   <= div_reg && (mag_b_reg == '0);
            state_reg <= S_DONE;
          end
        end
        default: begin
          hi          <= acc_reg[2*W-1:W];
          lo          <= acc_reg[W-1:0];
          done        <= 1'b1;
          div_by_zero <= dbz_reg;
          state_reg   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit at WIDTH=32 and WIDTH=8, against an arithmetic reference model.
module tb_muldiv_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;

  logic        start = 0, cancel = 0, hi_we = 0, lo_we = 0;
  logic [1:0]  op = 0;
  logic [31:0] a = 0, b = 0, wdata = 0;
  logic        busy, done, dbz;
  logic [31:0] hi, lo;

  logic        start8 = 0, cancel8 = 0, hi_we8 = 0, lo_we8 = 0;
  logic [1:0]  op8 = 0;
  logic [7:0]  a8 = 0, b8 = 0, wdata8 = 0;
  logic        busy8, done8, dbz8;
  logic [7:0]  hi8, lo8;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  muldiv_unit #(.WIDTH(32)) dut32 (
    .CLK(CLK), .RST(RST), .start(start), .op(op), .a(a), .b(b), .cancel(cancel),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .busy(busy), .done(done),
    .div_by_zero(dbz), .hi(hi), .lo(lo)
  );

  muldiv_unit #(.WIDTH(8)) dut8 (
    .CLK(CLK), .RST(RST), .start(start8), .op(op8), .a(a8), .b(b8), .cancel(cancel8),
    .hi_we(hi_we8), .lo_we(lo_we8), .wdata(wdata8), .busy(busy8), .done(done8),
    .div_by_zero(dbz8), .hi(hi8), .lo(lo8)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on w-bit operands.
  function automatic void model(input int w, input logic [1:0] o, input logic [63:0] x,
                                input logic [63:0] y, output logic [63:0] eh,
                                output logic [63:0] el, output logic ed);
    logic [63:0] mask, ux, uy, p;
    longint sx, sy, q, r;
    mask = (64'd1 << w) - 64'd1;
    ux = x & mask;
    uy = y & mask;
    sx = longint'(ux);
    sy = longint'(uy);
    if (ux[w-1]) sx = sx - (longint'(1) << w);
    if (uy[w-1]) sy = sy - (longint'(1) << w);
    ed = 1'b0;
    p  = '0;
    case (o)
      2'd0: p = ux * uy;
      2'd1: p = $unsigned(sx * sy);
      2'd2: begin
        if (uy == 0) begin p = (ux << w) | mask; ed = 1'b1; end
        else p = ((ux % uy) << w) | (ux / uy);
      end
      default: begin
        if (uy == 0) begin p = (ux << w) | mask; ed = 1'b1; end
        else begin
          q = sx / sy;
          r = sx % sy;
          p = (($unsigned(r) & mask) << w) | ($unsigned(q) & mask);
        end
      end
    endcase
    eh = (p >> w) & mask;
    el = p & mask;
  endfunction

  task automatic do_op32(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input string tag, input bit no_wait, input int restart_at, input bit post);
    logic [63:0] eh, el;
    logic ed;
    int lat, nbusy;
    model(32, o, 64'(x), 64'(y), eh, el, ed);
    if (!no_wait) @(negedge CLK);
    start = 1; op = o; a = x; b = y;
    lat = 0; nbusy = 0;
    do begin
      @(negedge CLK);
      lat++;
      start = (restart_at != 0 && lat == restart_at);
      op = 2'($urandom); a = $urandom; b = $urandom;
      if (busy) nbusy++;
    end while (!done && lat < 60);
    start = 0;
    chk({tag, ":done"}, 64'(done), 64'd1);
    chk({tag, ":latency"}, 64'(lat - 1), 64'd34);
    chk({tag, ":busy_cycles"}, 64'(nbusy), 64'd34);
    chk({tag, ":hi"}, 64'(hi), eh);
    chk({tag, ":lo"}, 64'(lo), el);
    chk({tag, ":dbz"}, 64'(dbz), 64'(ed));
    $display("op32 %s op=%0d a=%h b=%h hi=%h lo=%h dbz=%0d", tag, o, x, y, hi, lo, dbz);
    if (post) begin
      @(negedge CLK);
      chk({tag, ":done_pulse"}, 64'(done), 64'd0);
      chk({tag, ":dbz_pulse"}, 64'(dbz), 64'd0);
    end
  endtask

  task automatic do_op8(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y, input string tag);
    logic [63:0] eh, el;
    logic ed;
    int lat;
    model(8, o, 64'(x), 64'(y), eh, el, ed);
    @(negedge CLK);
    start8 = 1; op8 = o; a8 = x; b8 = y;
    lat = 0;
    do begin
      @(negedge CLK);
      lat++;
      start8 = 0;
    end while (!done8 && lat < 30);
    chk({tag, ":done"}, 64'(done8), 64'd1);
    chk({tag, ":latency"}, 64'(lat - 1), 64'd10);
    chk({tag, ":hi"}, 64'(hi8), eh);
    chk({tag, ":lo"}, 64'(lo8), el);
    chk({tag, ":dbz"}, 64'(dbz8), 64'(ed));
    $display("op8 %s op=%0d a=%h b=%h hi=%h lo=%h dbz=%0d", tag, o, x, y, hi8, lo8, dbz8);
  endtask

  initial begin
    logic [31:0] ph, pl, ra, rb;
    logic [1:0]  ro;
    int ndone;

    repeat (2) @(negedge CLK);
    chk("rst:busy", 64'(busy), 64'd0);
    chk("rst:done", 64'(done), 64'd0);
    chk("rst:dbz", 64'(dbz), 64'd0);
    chk("rst:hi", 64'(hi), 64'd0);
    chk("rst:lo", 64'(lo), 64'd0);
    chk("rst:hi8", 64'(hi8), 64'd0);
    $display("reset state checked");
    RST = 1;

    do_op32(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu_max", 0, 0, 1);
    do_op32(2'd1, 32'hFFFFFFFD, 32'd7, "mult_neg", 0, 0, 1);
    do_op32(2'd3, 32'hFFFFFFF9, 32'd2, "div_neg", 0, 0, 1);
    do_op32(2'd2, 32'd100, 32'd7, "divu", 0, 0, 1);
    do_op32(2'd2, 32'd5, 32'd0, "divu_zero", 0, 0, 1);
    do_op32(2'd3, 32'h80000000, 32'hFFFFFFFF, "div_ovf", 0, 0, 1);
    do_op32(2'd3, 32'h12345678, 32'd0, "div_zero", 0, 0, 1);
    do_op32(2'd2, 32'd1000, 32'd9, "restart_ignored", 0, 5, 1);
    do_op32(2'd1, 32'h7FFFFFFF, 32'h80000000, "b2b_first", 0, 0, 0);
    do_op32(2'd3, 32'h00000007, 32'hFFFFFFFE, "b2b_second", 1, 0, 1);

    // MTLO while busy, then cancel at edge k+10.
    ph = hi; pl = lo;
    @(negedge CLK); start = 1; op = 2'd0; a = $urandom; b = $urandom;
    @(negedge CLK); start = 0;
    @(negedge CLK); lo_we = 1; wdata = 32'h1234;
    @(negedge CLK); lo_we = 0;
    chk("lo_we_busy:lo", 64'(lo), 64'(pl));
    repeat (7) @(negedge CLK);
    cancel = 1;
    @(negedge CLK); cancel = 0;
    chk("cancel:busy", 64'(busy), 64'd0);
    chk("cancel:done", 64'(done), 64'd0);
    chk("cancel:hi", 64'(hi), 64'(ph));
    chk("cancel:lo", 64'(lo), 64'(pl));
    ndone = 0;
    repeat (40) begin
      @(negedge CLK);
      if (done) ndone++;
    end
    chk("cancel:no_done", 64'(ndone), 64'd0);
    chk("cancel:lo_after", 64'(lo), 64'(pl));
    $display("cancel hi=%h lo=%h done_pulses=%0d", hi, lo, ndone);

    // MTLO / MTHI while idle.
    @(negedge CLK); lo_we = 1; wdata = 32'h1234;
    @(negedge CLK); lo_we = 0;
    chk("lo_we_idle:lo", 64'(lo), 64'h1234);
    chk("lo_we_idle:hi", 64'(hi), 64'(ph));
    hi_we = 1; wdata = 32'hABCD0001;
    @(negedge CLK); hi_we = 0;
    chk("hi_we_idle:hi", 64'(hi), 64'hABCD0001);
    $display("hilo_write hi=%h lo=%h", hi, lo);

    // Asynchronous reset in the middle of RUN.
    @(negedge CLK); start = 1; op = 2'd0; a = 32'h0000FFFF; b = 32'd3;
    @(negedge CLK); start = 0;
    repeat (5) @(negedge CLK);
    #1 RST = 0;
    #1;
    chk("async_rst:busy", 64'(busy), 64'd0);
    chk("async_rst:hi", 64'(hi), 64'd0);
    chk("async_rst:lo", 64'(lo), 64'd0);
    chk("async_rst:done", 64'(done), 64'd0);
    @(negedge CLK); RST = 1;
    repeat (40) @(negedge CLK);
    chk("async_rst:discarded_lo", 64'(lo), 64'd0);
    $display("async_reset busy=%0d hi=%h lo=%h", busy, hi, lo);

    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(8, 31);
      if ($urandom_range(0, 7) == 0) rb = 32'd0;
      if ($urandom_range(0, 11) == 0) begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
      do_op32(ro, ra, rb, $sformatf("rand%0d", i), 0, 0, 1);
    end

    do_op8(2'd1, 8'h80, 8'h80, "w8_mult");
    do_op8(2'd3, 8'h80, 8'h03, "w8_div");
    do_op8(2'd3, 8'h80, 8'hFF, "w8_div_ovf");
    for (int i = 0; i < 8; i++)
      do_op8(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), $sformatf("w8_rand%0d", i));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised multi-cycle multiply/divide unit with architectural HI/LO result registers. It replaces the single-cycle product-into-HI/LO path of the processor datapath, and adds signed and unsigned multiply, signed and unsigned divide, direct HI/LO writes, and cancel. The processor control FSM issues an operation with `start`, stalls while `busy` is high, and reads `hi`/`lo` for MFHI/MFLO. The core is a radix-2 iterative shift-add / restoring-divide engine, one bit per clock.

## Interface
Parameters:
- `WIDTH`, default 32: operand width. HI and LO are each `WIDTH` bits; the full product is 2·`WIDTH` bits. Legal values are 4..64.

Ports:
- `CLK`  in  1: clock. All state changes on the rising edge.
- `RST`  in  1: reset, asynchronous, active-low. Clears all state while low.
- `start`  in  1: issue the operation selected by `op` using `a` and `b`. Sampled only when `busy`=0.
- `op`  in  2: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- `a`  in  WIDTH: multiplicand or dividend.
- `b`  in  WIDTH: multiplier or divisor.
- `cancel`  in  1: abort an in-flight operation.
- `hi_we`  in  1: MTHI, write `wdata` to HI.
- `lo_we`  in  1: MTLO, write `wdata` to LO.
- `wdata`  in  WIDTH: data for HI/LO writes.
- `busy`  out  1: operation in flight.
- `done`  out  1: one-cycle pulse; HI/LO updated this cycle.
- `div_by_zero`  out  1: pulses with `done` when a DIVU/DIV had `b`=0.
- `hi`  out  WIDTH: HI register. Product upper half, or remainder.
- `lo`  out  WIDTH: LO register. Product lower half, or quotient.

## Operation
- States are IDLE, RUN, FIXUP and DONE.
- **IDLE → RUN:** taken when `start`=1 and `busy`=0.
  - On entry the unit latches `op`, converts operands to magnitudes (signed ops only), records the result signs and clears the iteration counter.
- **RUN:** executes exactly `WIDTH` iterations, one bit per cycle.
  - Multiply: shift-add into a 2·`WIDTH` accumulator.
  - Divide: restoring shift-subtract on the remainder and quotient.
- **FIXUP:** applies sign correction, then moves to DONE.
  - MULT: negate the 2·`WIDTH` product if the operand signs differ.
  - DIV: negate the quotient if the operand signs differ; the remainder takes the dividend's sign; the quotient truncates toward zero.
- **DONE:** loads `hi`/`lo`, pulses `done`, and returns to IDLE.
- Divide by zero:
  - The full latency is still taken.
  - `lo` = all ones and `hi` = `a` as issued (unsigned bit pattern).
  - `div_by_zero`=1 with `done`.
- DIV of most-negative by −1: `lo` = most-negative value, `hi` = 0. No flag is raised.
- Widths: signed operands are two's complement, and all internal magnitudes are `WIDTH`+1 bits to hold |most-negative|.
- HI/LO writes:
  - `hi_we`/`lo_we` take effect at the edge only when `busy`=0 and the unit is not in DONE.
  - While busy they are ignored.
  - They may coincide with `start`. The write lands and the later DONE then overwrites HI/LO.
- `start` while `busy`=1 is ignored, with no queueing. `op`, `a` and `b` are don't-care after the issue edge.
- Cancel:
  - `cancel`=1 in RUN or FIXUP returns the unit to IDLE at that edge. `hi`/`lo` are unchanged and no `done` pulse occurs.
  - `cancel` in IDLE or DONE has no effect.
  - `cancel` together with `start` in IDLE means `start` wins.

## Timing
- Reset values, whether `RST` is low or asserted mid-operation:
  - State is IDLE.
  - `busy`=0, `done`=0, `div_by_zero`=0.
  - `hi`=0 and `lo`=0.
  - Any in-flight operation is discarded.
- For issue edge k:
  - RUN occupies edges k+1..k+`WIDTH`.
  - FIXUP occurs at edge k+`WIDTH`+1.
  - DONE occurs at edge k+`WIDTH`+2.
- `busy`:
  - Rises after edge k and stays high through the cycle following edge k+`WIDTH`+1.
  - Is low in the cycle after edge k+`WIDTH`+2, the DONE cycle.
- `done`, `div_by_zero` and the new `hi`/`lo` are visible in the same cycle, after edge k+`WIDTH`+2. The latency is `WIDTH`+2 edges (34 edges at `WIDTH`=32).
- Back-to-back issue: because `busy`=0 in the DONE cycle, `start` in that cycle is accepted. The issue period is `WIDTH`+3 edges.
- `hi`/`lo` are registered outputs and hold their value between updates.

## Test plan
- **Unsigned multiply, full latency.** MULTU `a`=0xFFFFFFFF, `b`=0xFFFFFFFF at edge k → `done` at edge k+34 with `hi`=0xFFFFFFFE, `lo`=0x00000001; `busy` high for exactly 34 cycles before it.
- **Signed multiply, signed and unsigned divide.**
  - MULT −3×7 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB.
  - DIV −7÷2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
  - DIVU 100÷7 → `lo`=14, `hi`=2.
- **Divide edge cases.**
  - DIVU 5÷0 → `lo`=0xFFFFFFFF, `hi`=5, `div_by_zero`=1 for one cycle.
  - DIV 0x80000000÷0xFFFFFFFF → `lo`=0x80000000, `hi`=0, `div_by_zero`=0.
- **Issue and HI/LO write rules.**
  - A second `start` at edge k+5 is ignored, and the result matches the first operation.
  - `start` in the DONE cycle is accepted, with the next `done` 34 edges later.
  - `lo_we` with `wdata`=0x1234 while busy → `lo` is unchanged.
  - `lo_we` with `wdata`=0x1234 while idle → `lo`=0x1234 the next cycle.
- **Cancel and reset mid-operation.**
  - `cancel` at edge k+10 → `busy`=0 the next cycle, no `done`, and `hi`/`lo` keep their prior values.
  - `RST` low mid-RUN → `hi`=`lo`=0 and `busy`=0 immediately, asynchronously.
- **Narrow width.** `WIDTH`=8: MULT 0x80×0x80 → `hi`=0x40, `lo`=0x00, with `done` at edge k+10. DIV 0x80÷0x03 → `lo`=0xD6, `hi`=0xFE.
